// File: rtl/ysyx_22040088_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22040088_seq_ctrl
//
// Multi-cycle sequencer for the IFU/IDU/EXU core. Each instruction is fetched
// over an imem req/ready/rvalid handshake and latched into an instruction
// register. The sequencer then gives the combinational datapath one execute
// cycle, runs a data-memory phase for loads and stores, and finally pulses
// the PC and regfile write enables. An ebreak halts the core. A memory
// handshake that stalls for TIMEOUT_CYC cycles parks the core in a sticky
// error state.
//
// Parameters
//   TIMEOUT_CYC  cycles allowed in any memory-wait state before S_ERR
//   CNT_W        width of cycle_cnt / instret_cnt
//
// Ports
//   clk          core clock, rising edge
//   rst          asynchronous, active-low reset
//   run          start execution (sampled only while idle)
//   imem_req     instruction fetch request
//   imem_ready   imem accepts the request this cycle
//   imem_rvalid  fetched instruction valid on imem_rdata
//   imem_rdata   fetched instruction
//   inst         registered instruction to IDU/EXU/ebreak logic
//   dmem_req     data memory request
//   dmem_we      1 = store, 0 = load (valid while dmem_req=1)
//   dmem_ready   dmem accepts the request this cycle
//   dmem_rvalid  load data valid
//   pc_we        one-cycle pulse: IFU loads nextpc
//   rf_we        one-cycle pulse: regfile write enable
//   halted       ebreak retired, sticky until reset
//   err          memory timeout, sticky until reset
//   cycle_cnt    active cycles (wraps)
//   instret_cnt  retired instructions (wraps)
// ---------------------------------------------------------------------------
module ysyx_22040088_seq_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    input  logic             dmem_rvalid,
    output logic             pc_we,
    output logic             rf_we,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [31:0] EBREAK    = 32'h00100073;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    // The timer only has to reach TIMEOUT_CYC-1.
    localparam int TIMER_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_IF_REQ,
        S_IF_WAIT,
        S_EX,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WB,
        S_HALT,
        S_ERR
    } state_t;

    state_t             state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic [31:0]        inst_reg, inst_next;
    logic [CNT_W-1:0]   cycle_cnt_reg, instret_cnt_reg;

    logic               is_load, is_store, is_branch, is_ebreak;
    logic               in_wait, wait_done;

    assign is_load   = (inst_reg[6:0] == OP_LOAD);
    assign is_store  = (inst_reg[6:0] == OP_STORE);
    assign is_branch = (inst_reg[6:0] == OP_BRANCH);
    assign is_ebreak = (inst_reg == EBREAK);

    // ------------------------------------------------------------------
    // State, timer and instruction register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            timer_reg <= '0;
            inst_reg  <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            inst_reg  <= inst_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        inst_next  = inst_reg;
        timer_next = '0;
        in_wait    = 1'b0;
        wait_done  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_IF_REQ;
            end
            S_IF_REQ: begin
                in_wait   = 1'b1;
                wait_done = imem_ready;
                if (imem_ready) state_next = S_IF_WAIT;
            end
            S_IF_WAIT: begin
                in_wait   = 1'b1;
                wait_done = imem_rvalid;
                if (imem_rvalid) begin
                    inst_next  = imem_rdata;
                    state_next = S_EX;
                end
            end
            S_EX: begin
                if (is_ebreak)                 state_next = S_HALT;
                else if (is_load || is_store)  state_next = S_MEM_REQ;
                else                           state_next = S_WB;
            end
            S_MEM_REQ: begin
                in_wait   = 1'b1;
                wait_done = dmem_ready;
                // A store is complete once the memory accepts it.
                if (dmem_ready) state_next = is_store ? S_WB : S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                in_wait   = 1'b1;
                wait_done = dmem_rvalid;
                if (dmem_rvalid) state_next = S_WB;
            end
            S_WB:    state_next = S_IF_REQ;
            S_HALT:  state_next = S_HALT;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase

        // Any wait state is entered with timer_next defaulted to zero.
        // A handshake completing on the last allowed cycle still wins
        // because the timeout only applies while the handshake is unmet.
        if (in_wait && !wait_done) begin
            if (timer_reg == TIMER_LAST) state_next = S_ERR;
            else                         timer_next = timer_reg + TIMER_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
        end else begin
            if (state_reg != S_IDLE && state_reg != S_HALT && state_reg != S_ERR)
                cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
            if (state_reg == S_WB)
                instret_cnt_reg <= instret_cnt_reg + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    assign imem_req    = (state_reg == S_IF_REQ);
    assign dmem_req    = (state_reg == S_MEM_REQ);
    assign dmem_we     = (state_reg == S_MEM_REQ) && is_store;
    assign pc_we       = (state_reg == S_WB);
    assign rf_we       = (state_reg == S_WB) && !is_store && !is_branch;
    assign halted      = (state_reg == S_HALT);
    assign err         = (state_reg == S_ERR);
    assign inst        = inst_reg;
    assign cycle_cnt   = cycle_cnt_reg;
    assign instret_cnt = instret_cnt_reg;

endmodule
